// File: rtl/shift_and_matcher_pkg.sv
// ---------------------------------------------------------------------------
// shift_and_matcher_pkg
// Shared definitions for the Shift-And matcher and its downstream consumers:
// default widths, the match event record and a saturating counter helper.
// ---------------------------------------------------------------------------
package shift_and_matcher_pkg;

  localparam int STATE_WIDTH_DEF = 8;
  localparam int POS_WIDTH_DEF   = 16;
  localparam int COUNT_WIDTH     = 16;

  // Match event as seen by consumers: end position in record, first-in-record.
  typedef struct packed {
    logic [POS_WIDTH_DEF-1:0] pos;
    logic                     first;
  } match_event_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc16(input logic [COUNT_WIDTH-1:0] value);
    logic [COUNT_WIDTH-1:0] result;
    if (value == {COUNT_WIDTH{1'b1}}) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_and_matcher_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Generic synchronous FIFO with full/empty flags. The head entry is read
// straight out of the storage array at the read pointer, so it holds steady
// while the consumer stalls. A push into a full FIFO is accepted only when a
// pop happens in the same cycle.
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset (flushes contents)
//   push, push_data write request and data
//   pop             read request (ignored when empty)
//   full, empty     occupancy flags
//   head_data       oldest entry
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Extra pointer MSB distinguishes full from empty when the indices meet.
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign head_data = mem_r[rd_ptr_r[AW-1:0]];

  // Qualify push/pop against the current occupancy.
  always_comb begin
    pop_ok_s  = 1'b0;
    push_ok_s = 1'b0;
    if (pop && !empty) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
    if (push && (!full || pop_ok_s)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
  end

  // Storage and pointers; reset also clears contents so the head reads zero.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/shift_and_matcher.sv
// ---------------------------------------------------------------------------
// shift_and_matcher
// Bit-parallel Shift-And matcher. Each mask beat advances the NFA state
// vector; reaching a selected final state queues a match event carrying the
// record position of the last matched character.
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   s_axis_tvalid/tdata    per-character mask beat (no backpressure)
//   s_axis_tuser           first beat of a new record
//   accept_mask            final-state select (quasi-static)
//   anchored               only match patterns starting at position 0
//   m_axis_tvalid/tready   match event handshake
//   m_axis_tdata/tuser     end position / first match of the record
//   match_count            saturating count of all hits (dropped included)
//   overflow               sticky: an event was dropped on a full FIFO
// ---------------------------------------------------------------------------
module shift_and_matcher
  import shift_and_matcher_pkg::*;
#(
  parameter int STATE_WIDTH = STATE_WIDTH_DEF,
  parameter int POS_WIDTH   = POS_WIDTH_DEF,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   s_axis_tvalid,
  input  logic [STATE_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tuser,
  input  logic [STATE_WIDTH-1:0] accept_mask,
  input  logic                   anchored,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [POS_WIDTH-1:0]   m_axis_tdata,
  output logic                   m_axis_tuser,
  output logic [15:0]            match_count,
  output logic                   overflow
);

  logic [STATE_WIDTH-1:0] d_r;
  logic [POS_WIDTH-1:0]   pos_r;
  logic                   first_pending_r;

  logic [STATE_WIDTH-1:0] d_base_s;
  logic [POS_WIDTH-1:0]   p_s;
  logic                   inject_s;
  logic [STATE_WIDTH-1:0] d_next_s;
  logic                   hit_s;
  logic                   ev_first_s;
  logic [POS_WIDTH-1:0]   pos_inc_s;
  logic                   pop_s;
  logic                   drop_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [POS_WIDTH:0]     head_s;

  // Matcher core: choose base state, step the NFA, detect a hit.
  always_comb begin
    d_base_s   = {STATE_WIDTH{1'b0}};
    p_s        = {POS_WIDTH{1'b0}};
    inject_s   = 1'b0;
    d_next_s   = {STATE_WIDTH{1'b0}};
    hit_s      = 1'b0;
    ev_first_s = 1'b0;
    pos_inc_s  = {POS_WIDTH{1'b0}};
    // A record start never inherits state from the previous record.
    if (s_axis_tuser) begin
      d_base_s = {STATE_WIDTH{1'b0}};
      p_s      = {POS_WIDTH{1'b0}};
    end else begin
      d_base_s = d_r;
      p_s      = pos_r;
    end
    inject_s = !anchored || (p_s == {POS_WIDTH{1'b0}});
    d_next_s = ((d_base_s << 1) | {{(STATE_WIDTH-1){1'b0}}, inject_s}) & s_axis_tdata;
    if (s_axis_tvalid && (|(d_next_s & accept_mask))) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
    ev_first_s = s_axis_tuser || first_pending_r;
    if (p_s == {POS_WIDTH{1'b1}}) begin
      pos_inc_s = p_s;
    end else begin
      pos_inc_s = p_s + {{(POS_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign m_axis_tvalid = !fifo_empty_s;
  assign pop_s         = m_axis_tvalid && m_axis_tready;
  assign drop_s        = hit_s && fifo_full_s && !pop_s;
  assign m_axis_tdata  = head_s[POS_WIDTH:1];
  assign m_axis_tuser  = head_s[0];

  // NFA state, record position, first-match tracking and statistics.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      d_r             <= {STATE_WIDTH{1'b0}};
      pos_r           <= {POS_WIDTH{1'b0}};
      first_pending_r <= 1'b0;
      match_count     <= 16'd0;
      overflow        <= 1'b0;
    end else if (s_axis_tvalid) begin
      d_r   <= d_next_s;
      pos_r <= pos_inc_s;
      if (hit_s) begin
        first_pending_r <= 1'b0;
        match_count     <= sat_inc16(match_count);
      end else if (s_axis_tuser) begin
        first_pending_r <= 1'b1;
      end
      if (drop_s) begin
        overflow <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (POS_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (hit_s),
    .push_data ({p_s, ev_first_s}),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head_data (head_s)
  );

endmodule

// File: tb/tb_shift_and_matcher.sv
// ---------------------------------------------------------------------------
// tb_shift_and_matcher
// Self-checking bench: each test drives mask beats and pushes the events it
// expects into a scoreboard queue; a monitor pops and compares every event
// the DUT hands over.
// ---------------------------------------------------------------------------
module tb_shift_and_matcher;
  import shift_and_matcher_pkg::*;

  logic        aclk;
  logic        aresetn;
  logic        s_axis_tvalid;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tuser;
  logic [7:0]  accept_mask;
  logic        anchored;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic [15:0] match_count;
  logic        overflow;

  int pass_cnt;
  int total_cnt;
  match_event_t exp_q[$];

  localparam logic [7:0] MA = 8'h01;
  localparam logic [7:0] MB = 8'h02;
  localparam logic [7:0] MX = 8'h00;

  shift_and_matcher #(.STATE_WIDTH(8), .POS_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .accept_mask   (accept_mask),
    .anchored      (anchored),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .match_count   (match_count),
    .overflow      (overflow)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Scoreboard monitor: every handshake must match the oldest expected event.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      total_cnt = total_cnt + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: got pos=%0d first=%0b, expected no event", m_axis_tdata, m_axis_tuser);
      end else begin
        match_event_t e;
        e = exp_q.pop_front();
        if (m_axis_tdata !== e.pos || m_axis_tuser !== e.first) begin
          $display("FAIL event: got pos=%0d first=%0b, expected pos=%0d first=%0b",
                   m_axis_tdata, m_axis_tuser, e.pos, e.first);
        end else begin
          pass_cnt = pass_cnt + 1;
        end
      end
    end
  end

  task automatic expect_ev(input int p, input bit f);
    match_event_t e;
    e.pos   = p[15:0];
    e.first = f;
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic [7:0] m, input bit u);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = m;
    s_axis_tuser  = u;
  endtask

  task automatic idle();
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    exp_q.delete();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  // Waits until the scoreboard is drained, then moves to the next negedge.
  task automatic wait_empty(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge aclk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge aclk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    total_cnt += 5;
    if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %0b expected 0", m_axis_tvalid); else pass_cnt++;
    if (m_axis_tdata !== 16'd0) $display("FAIL reset_tdata: got %0h expected 0", m_axis_tdata); else pass_cnt++;
    if (m_axis_tuser !== 1'b0) $display("FAIL reset_tuser: got %0b expected 0", m_axis_tuser); else pass_cnt++;
    if (match_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", match_count); else pass_cnt++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b expected 0", overflow); else pass_cnt++;
    #1;
    aresetn = 1'b1;
  endtask

  task automatic test_unanchored();
    bit ok;
    do_reset();
    accept_mask = MB; anchored = 1'b0; m_axis_tready = 1'b1;
    beat(MX, 1'b1);
    beat(MA, 1'b0);
    beat(MB, 1'b0); expect_ev(2, 1'b1);
    beat(MA, 1'b0);
    beat(MB, 1'b0); expect_ev(4, 1'b0);
    idle();
    wait_empty(ok);
    total_cnt += 2;
    if (!ok) $display("FAIL unanchored_drain: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
    if (match_count !== 16'd2) $display("FAIL unanchored_count: got %0d expected 2", match_count); else pass_cnt++;
  endtask

  task automatic test_anchored();
    bit ok;
    do_reset();
    accept_mask = MB; anchored = 1'b1; m_axis_tready = 1'b1;
    beat(MX, 1'b1); beat(MA, 1'b0); beat(MB, 1'b0); beat(MA, 1'b0); beat(MB, 1'b0);
    idle();
    @(negedge aclk);
    total_cnt += 2;
    if (match_count !== 16'd0) $display("FAIL anchored_none_count: got %0d expected 0", match_count); else pass_cnt++;
    if (m_axis_tvalid !== 1'b0) $display("FAIL anchored_none_tvalid: got %0b expected 0", m_axis_tvalid); else pass_cnt++;
    beat(MA, 1'b1);
    beat(MB, 1'b0); expect_ev(1, 1'b1);
    beat(MA, 1'b0); beat(MB, 1'b0);
    idle();
    wait_empty(ok);
    total_cnt += 2;
    if (!ok) $display("FAIL anchored_drain: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
    if (match_count !== 16'd1) $display("FAIL anchored_count: got %0d expected 1", match_count); else pass_cnt++;
  endtask

  task automatic test_boundary();
    bit ok;
    do_reset();
    accept_mask = MB; anchored = 1'b0; m_axis_tready = 1'b1;
    beat(MA, 1'b1);
    beat(MB, 1'b1);
    idle();
    @(negedge aclk);
    total_cnt += 1;
    if (match_count !== 16'd0) $display("FAIL boundary_no_hit: got %0d expected 0", match_count); else pass_cnt++;
    // 'b' sat at position 0, so the next "ab" ends at position 2.
    beat(MA, 1'b0);
    beat(MB, 1'b0); expect_ev(2, 1'b1);
    idle();
    wait_empty(ok);
    total_cnt += 1;
    if (!ok) $display("FAIL boundary_drain: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
    accept_mask = 8'h00;
    beat(MA, 1'b1); beat(MB, 1'b0);
    idle();
    @(negedge aclk);
    total_cnt += 1;
    if (match_count !== 16'd1) $display("FAIL zero_accept_count: got %0d expected 1", match_count); else pass_cnt++;
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    accept_mask = MA; anchored = 1'b0; m_axis_tready = 1'b0;
    beat(MA, 1'b1); expect_ev(0, 1'b1);
    for (int i = 1; i < 6; i++) begin
      beat(MA, 1'b0);
      if (i < 4) expect_ev(i, 1'b0);
    end
    idle();
    @(negedge aclk);
    total_cnt += 4;
    if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0b expected 1", overflow); else pass_cnt++;
    if (match_count !== 16'd6) $display("FAIL ovf_count: got %0d expected 6", match_count); else pass_cnt++;
    if (m_axis_tvalid !== 1'b1) $display("FAIL ovf_tvalid: got %0b expected 1", m_axis_tvalid); else pass_cnt++;
    if (m_axis_tdata !== 16'd0) $display("FAIL ovf_head_stable: got %0d expected 0", m_axis_tdata); else pass_cnt++;
    m_axis_tready = 1'b1;
    wait_empty(ok);
    total_cnt += 2;
    if (!ok) $display("FAIL ovf_drain: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
    if (m_axis_tvalid !== 1'b0) $display("FAIL ovf_drained_tvalid: got %0b expected 0", m_axis_tvalid); else pass_cnt++;
  endtask

  task automatic test_full_pop();
    bit ok;
    do_reset();
    accept_mask = MA; anchored = 1'b0; m_axis_tready = 1'b0;
    beat(MA, 1'b1); expect_ev(0, 1'b1);
    for (int i = 1; i < 4; i++) begin
      beat(MA, 1'b0); expect_ev(i, 1'b0);
    end
    // FIFO is full when this beat arrives; pop it in the same cycle.
    beat(MA, 1'b0); expect_ev(4, 1'b0);
    m_axis_tready = 1'b1;
    idle();
    m_axis_tready = 1'b0;
    @(negedge aclk);
    total_cnt += 3;
    if (overflow !== 1'b0) $display("FAIL fullpop_overflow: got %0b expected 0", overflow); else pass_cnt++;
    if (match_count !== 16'd5) $display("FAIL fullpop_count: got %0d expected 5", match_count); else pass_cnt++;
    if (m_axis_tdata !== 16'd1) $display("FAIL fullpop_head: got %0d expected 1", m_axis_tdata); else pass_cnt++;
    // Still four entries deep: another hit without a pop must drop.
    beat(MA, 1'b0);
    idle();
    @(negedge aclk);
    total_cnt += 1;
    if (overflow !== 1'b1) $display("FAIL fullpop_still_full: got %0b expected 1", overflow); else pass_cnt++;
    m_axis_tready = 1'b1;
    wait_empty(ok);
    total_cnt += 2;
    if (!ok) $display("FAIL fullpop_drain: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
    if (m_axis_tvalid !== 1'b0) $display("FAIL fullpop_drained_tvalid: got %0b expected 0", m_axis_tvalid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    accept_mask = MA; anchored = 1'b0; m_axis_tready = 1'b0;
    beat(MA, 1'b1);
    beat(MA, 1'b0);
    idle();
    do_reset();
    @(negedge aclk);
    total_cnt += 4;
    if (m_axis_tvalid !== 1'b0) $display("FAIL midreset_tvalid: got %0b expected 0", m_axis_tvalid); else pass_cnt++;
    if (m_axis_tdata !== 16'd0) $display("FAIL midreset_tdata: got %0h expected 0", m_axis_tdata); else pass_cnt++;
    if (match_count !== 16'd0) $display("FAIL midreset_count: got %0d expected 0", match_count); else pass_cnt++;
    if (overflow !== 1'b0) $display("FAIL midreset_overflow: got %0b expected 0", overflow); else pass_cnt++;
    accept_mask = MB; m_axis_tready = 1'b1;
    beat(MA, 1'b1);
    beat(MB, 1'b0); expect_ev(1, 1'b1);
    idle();
    wait_empty(ok);
    total_cnt += 2;
    if (!ok) $display("FAIL midreset_drain: got %0d pending expected 0", exp_q.size()); else pass_cnt++;
    if (match_count !== 16'd1) $display("FAIL midreset_after_count: got %0d expected 1", match_count); else pass_cnt++;
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tuser  = 1'b0;
    accept_mask   = 8'h00;
    anchored      = 1'b0;
    m_axis_tready = 1'b0;
    test_reset();
    test_unanchored();
    test_anchored();
    test_boundary();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
